reg_bus_initiator: RTL and testbench
====================================

Name: reg_bus_initiator

Overview:
Initiator side of the team's simple register bus, which uses write_en/read_en strobes, addr, data and a ready response. It accepts commands from upstream logic into a small command FIFO and issues them one at a time as bus writes or reads. Read data, or a timeout error, is returned on a valid/ready response channel. It sits between a host or control sequencer and a DATA_WIDTH/ADDR_WIDTH register-bus responder.

Parameters:
DATA_WIDTH, 8, width of write and read data.
ADDR_WIDTH, 4, width of the register address.
CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
TIMEOUT, 15, maximum number of cycles read strobe stays high without bus_ready_i before an error is reported; at least 1.

Ports:
clk_i  input  1  single clock; all logic on rising edge.
rst_i  input  1  synchronous reset, active-high.
cmd_valid_i  input  1  command offered.
cmd_ready_o  output  1  command FIFO not full.
cmd_write_i  input  1  1 = write, 0 = read.
cmd_addr_i  input  ADDR_WIDTH  target address.
cmd_wdata_i  input  DATA_WIDTH  write data; ignored for reads.
rsp_valid_o  output  1  read response available.
rsp_ready_i  input  1  response consumed.
rsp_rdata_o  output  DATA_WIDTH  read data; 0 on error.
rsp_err_o  output  1  read timed out.
bus_write_en_o  output  1  write strobe to responder.
bus_read_en_o  output  1  read strobe to responder.
bus_addr_o  output  ADDR_WIDTH  bus address.
bus_wdata_o  output  DATA_WIDTH  bus write data.
bus_rdata_i  input  DATA_WIDTH  responder read data.
bus_ready_i  input  1  responder read-complete pulse.
busy_o  output  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset: all outputs 0 except cmd_ready_o, which is 1. FIFO emptied, FSM goes to IDLE, timeout counter cleared. An in-flight read is abandoned and its strobe drops at the first edge where rst_i is sampled high. A pending response is discarded.
- FIFO push: on cmd_valid_i && cmd_ready_o, stores {write, addr, wdata}.
- cmd_ready_o = !full. There is no pass-through when full, even if a pop occurs in the same cycle. Simultaneous push and pop when not full is allowed, and the count is unchanged.
- All bus_* and rsp_* outputs are registered.
- FSM states: IDLE, WR, RD, RSP.
- IDLE: if the FIFO is non-empty, pop the head, load bus_addr_o and bus_wdata_o, and go to WR or RD.
- Latency: a command pushed into an empty FIFO at edge N has its strobe high from edge N+2.
- WR: bus_write_en_o = 1 for exactly one cycle, then return to IDLE. Writes produce no response. Back-to-back writes therefore give a strobe every 2 cycles.
- RD: bus_read_en_o is held at 1. The counter increments each cycle in RD.
  - bus_ready_i sampled high: capture bus_rdata_i into rsp_rdata_o, set rsp_err_o = 0, drop the strobe, go to RSP.
  - Counter reaches TIMEOUT without ready: set rsp_rdata_o = 0, rsp_err_o = 1, drop the strobe, go to RSP.
  - Ready arriving in the same cycle as the timeout: ready wins, no error.
- RSP: rsp_valid_o = 1, and rsp_rdata_o/rsp_err_o are held stable until rsp_ready_i is high. Then rsp_valid_o clears and the FSM returns to IDLE. No new bus command issues while a response is pending.
- bus_ready_i outside RD is ignored.
- bus_addr_o and bus_wdata_o hold their last values after a strobe. Strobes are never high simultaneously.
- busy_o is combinational from the FSM state and the FIFO count.

Test Plan:
- Reset, then write addr 0x3 data 0xA5 → one cycle of bus_write_en_o with bus_addr_o = 0x3 and bus_wdata_o = 0xA5, two edges after acceptance; no rsp_valid_o; busy_o returns to 0.
- Read addr 0x7; responder pulses bus_ready_i on the 3rd read_en cycle with data 0x5C → rsp_valid_o = 1, rsp_rdata_o = 0x5C, rsp_err_o = 0. Hold rsp_ready_i low for 4 cycles → outputs stay stable and no new strobe is issued.
- Read with bus_ready_i never asserted → bus_read_en_o is high for exactly 15 cycles, then rsp_err_o = 1 and rsp_rdata_o = 0x00.
- Ready on the 15th read cycle, i.e. coincident with timeout → rsp_err_o = 0 and the data is captured.
- Push 5 commands back-to-back while the first is stalled in RD → cmd_ready_o drops after 4 accepted. All 4 issue in order (W0x1, R0x2, W0x4, R0x8) with correct strobes.
- Assert rst_i for 1 cycle mid-read with 2 commands queued → strobe drops at the next edge, FIFO is empty, no response appears, and the bus stays idle afterward.

Source files
------------

// File: rtl/reg_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : reg_bus_initiator
// Description : Queues register-bus commands in a small FIFO and issues them
//               one at a time as write/read strobes, returning read data or a
//               timeout error on a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  bus_write_en_o,
    output logic                  bus_read_en_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ready_i,
    output logic                  busy_o
);

    localparam int c_PTR_W   = $clog2(CMD_DEPTH);
    localparam int c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam int c_ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(CMD_DEPTH);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0]  r_mem [CMD_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [c_ENTRY_W-1:0]  w_head;
    logic                  w_head_write;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_wdata;

    assign w_full       = (r_count == c_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = cmd_valid_i && !w_full;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_write = w_head[c_ENTRY_W-1];
    assign w_head_addr  = w_head[DATA_WIDTH +: ADDR_WIDTH];
    assign w_head_wdata = w_head[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wr_en;
    logic                  w_wr_en_nxt;
    logic                  r_rd_en;
    logic                  w_rd_en_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic                  r_rsp_valid;
    logic                  w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  r_rsp_err;
    logic                  w_rsp_err_nxt;
    logic [c_CNT_W-1:0]    r_to_cnt;
    logic [c_CNT_W-1:0]    w_to_cnt_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
        end
    end

    // The strobe register rises one edge after the command is popped, so
    // the address is already stable on the bus when the strobe appears.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_en_nxt     = 1'b0;
        w_rd_en_nxt     = r_rd_en;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_to_cnt_nxt    = r_to_cnt;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_addr_nxt   = w_head_addr;
                    w_wdata_nxt  = w_head_wdata;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = w_head_write ? S_WR : S_RD;
                end
            end
            S_WR: begin
                w_wr_en_nxt = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_RD: begin
                if (!r_rd_en) begin
                    w_rd_en_nxt = 1'b1;
                end else if (bus_ready_i) begin
                    w_rd_en_nxt     = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = bus_rdata_i;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = S_RSP;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_rd_en_nxt     = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_RSP;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + c_CNT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_o    = !w_full;
    assign busy_o         = !w_empty || (r_state != S_IDLE);
    assign bus_write_en_o = r_wr_en;
    assign bus_read_en_o  = r_rd_en;
    assign bus_addr_o     = r_addr;
    assign bus_wdata_o    = r_wdata;
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_rdata_o    = r_rsp_rdata;
    assign rsp_err_o      = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bus_initiator
// Description : Directed and randomized self-checking bench for
//               reg_bus_initiator with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_initiator;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ready;
    logic          busy;

    always #5 clk = ~clk;

    reg_bus_initiator #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CMD_DEPTH (DEPTH),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .bus_write_en_o(wr_en),
        .bus_read_en_o (rd_en),
        .bus_addr_o    (bus_addr),
        .bus_wdata_o   (bus_wdata),
        .bus_rdata_i   (bus_rdata),
        .bus_ready_i   (bus_ready),
        .busy_o        (busy)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    cmd_t exp_q[$];      // accepted commands not yet seen on the bus
    rsp_t rsp_q[$];      // responses owed to the host, in order
    cmd_t ev_q[$];       // log of every strobe seen

    int            rd_cycles     = 0;
    int            cur_ready_at  = 0;
    int            next_ready_at = 0;
    int            last_rd_len   = 0;
    logic [DW-1:0] cur_rdata     = '0;
    logic [DW-1:0] next_rdata    = '0;
    bit            rand_mode     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: account for handshakes the coming edge commits, then
    // observe the bus and play the responder for the next edge.
    task automatic tick();
        cmd_t c;
        rsp_t r;
        if (!rst && cmd_valid && cmd_ready) begin
            c = {cmd_write, cmd_addr, cmd_wdata};
            exp_q.push_back(c);
        end
        if (!rst && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                r = rsp_q.pop_front();
                chk("rsp_err", rsp_err, r.err);
                chk("rsp_rdata", rsp_rdata, r.data);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            rsp_q.delete();
            rd_cycles = 0;
        end
        if (wr_en || rd_en) begin
            chk("strobe_exclusive", wr_en && rd_en, 1'b0);
            chk("strobe_while_rsp", rsp_valid, 1'b0);
        end
        if (wr_en) begin
            if (exp_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                c = exp_q.pop_front();
                chk("wr_kind", c.wr, 1'b1);
                chk("wr_addr", bus_addr, c.addr);
                chk("wr_data", bus_wdata, c.wdata);
                ev_q.push_back(c);
            end
        end
        if (rd_en) begin
            rd_cycles++;
            if (rd_cycles == 1) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    c = exp_q.pop_front();
                    chk("rd_kind", c.wr, 1'b0);
                    chk("rd_addr", bus_addr, c.addr);
                    ev_q.push_back(c);
                end
                cur_ready_at = rand_mode ? int'($urandom_range(1, TO + 3)) : next_ready_at;
                cur_rdata    = rand_mode ? DW'($urandom) : next_rdata;
                r.err  = !(cur_ready_at >= 1 && cur_ready_at <= TO);
                r.data = r.err ? '0 : cur_rdata;
                rsp_q.push_back(r);
            end
        end else if (rd_cycles != 0) begin
            last_rd_len = rd_cycles;
            chk("rd_len", rd_cycles, (cur_ready_at >= 1 && cur_ready_at <= TO) ? cur_ready_at : TO);
            rd_cycles = 0;
        end
        bus_ready = rd_en && (rd_cycles == cur_ready_at);
        bus_rdata = bus_ready ? cur_rdata : DW'($urandom);
        if (rand_mode && !rd_en && rsp_valid) bus_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin tick(); n++; end
        chk("wait_rsp", rsp_valid, 1'b1);
    endtask

    task automatic wait_rd(input int budget);
        int n = 0;
        while (!rd_en && n < budget) begin tick(); n++; end
        chk("wait_rd", rd_en, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        rsp_ready = 1'b1;
        while ((busy || rsp_valid || wr_en || rd_en) && n < budget) begin tick(); n++; end
        chk("wait_idle", busy || rsp_valid || wr_en || rd_en, 1'b0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n_acc;
        int   activity;
        logic acc [5];
        cmd_t blk [5];

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_strobes", {wr_en, rd_en}, 2'b00);
        chk("rst_addr_data", {bus_addr, bus_wdata}, 12'h000);
        chk("rst_busy", busy, 1'b0);

        // single write: strobe two edges after acceptance
        push(1'b1, 4'h3, 8'hA5);
        chk("wr_busy_after_push", busy, 1'b1);
        chk("wr_strobe_n0", wr_en, 1'b0);
        tick();
        chk("wr_strobe_n1", wr_en, 1'b0);
        tick();
        chk("wr_strobe_n2", wr_en, 1'b1);
        chk("wr_bus_addr", bus_addr, 4'h3);
        chk("wr_bus_wdata", bus_wdata, 8'hA5);
        tick();
        chk("wr_strobe_n3", wr_en, 1'b0);
        chk("wr_no_rsp", rsp_valid, 1'b0);
        chk("wr_busy_done", busy, 1'b0);
        chk("wr_addr_hold", bus_addr, 4'h3);

        // read answered on third strobe cycle, response held under backpressure
        next_ready_at = 3; next_rdata = 8'h5C;
        push(1'b0, 4'h7, 8'h00);
        tick();
        chk("rd_strobe_n1", rd_en, 1'b0);
        tick();
        chk("rd_strobe_n2", rd_en, 1'b1);
        wait_rsp(30);
        chk("rd_data", rsp_rdata, 8'h5C);
        chk("rd_err", rsp_err, 1'b0);
        chk("rd_len3", last_rd_len, 32'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) push(1'b1, 4'hB, 8'h11);
            else tick();
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_rdata", rsp_rdata, 8'h5C);
            chk("hold_err", rsp_err, 1'b0);
            chk("hold_no_strobe", {wr_en, rd_en}, 2'b00);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 1'b0);
        wait_idle(20);

        // read that never gets ready
        next_ready_at = 0; next_rdata = 8'hEE;
        push(1'b0, 4'h9, 8'h00);
        wait_rsp(40);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 8'h00);
        chk("to_len", last_rd_len, 32'd15);
        wait_idle(10);

        // ready coincident with timeout
        next_ready_at = 15; next_rdata = 8'h3C;
        push(1'b0, 4'hE, 8'h00);
        wait_rsp(40);
        chk("tie_err", rsp_err, 1'b0);
        chk("tie_rdata", rsp_rdata, 8'h3C);
        chk("tie_len", last_rd_len, 32'd15);
        wait_idle(10);

        // fill the FIFO behind a stalled read
        ev_q.delete();
        next_ready_at = 12; next_rdata = 8'h77;
        push(1'b0, 4'h0, 8'h00);
        wait_rd(10);
        next_ready_at = 2; next_rdata = 8'h99;
        blk[0] = {1'b1, 4'h1, 8'h11};
        blk[1] = {1'b0, 4'h2, 8'h00};
        blk[2] = {1'b1, 4'h4, 8'h44};
        blk[3] = {1'b0, 4'h8, 8'h00};
        blk[4] = {1'b1, 4'hF, 8'hFF};
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            {cmd_write, cmd_addr, cmd_wdata} = blk[i];
            acc[i] = cmd_ready;
            if (cmd_ready) n_acc++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("fifo_accepted", n_acc, 32'd4);
        chk("fifo_fifth_rejected", acc[4], 1'b0);
        chk("fifo_full_ready", cmd_ready, 1'b0);
        wait_idle(150);
        chk("order_count", ev_q.size(), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk("order_kind", ev_q[i+1].wr, blk[i].wr);
            chk("order_addr", ev_q[i+1].addr, blk[i].addr);
        end

        // reset in the middle of a read with two commands queued
        next_ready_at = 0;
        push(1'b0, 4'hA, 8'h00);
        wait_rd(10);
        push(1'b1, 4'h5, 8'h55);
        push(1'b0, 4'h6, 8'h00);
        chk("pre_rst_rd", rd_en, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_strobe", rd_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_rsp", rsp_valid, 1'b0);
        rsp_ready = 1'b1;
        activity = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (wr_en || rd_en || rsp_valid || busy) activity++;
        end
        rsp_ready = 1'b0;
        chk("post_rst_idle", activity, 32'd0);

        // randomized traffic against the model
        rand_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
        end
        cmd_valid = 1'b0;
        wait_idle(400);
        chk("drain_cmds", exp_q.size(), 32'd0);
        chk("drain_rsps", rsp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
